// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-engine state encoding, default sizes and the address-ignore predicate.
package regfile_pkg;

  typedef enum logic {CLEAR, READY} state_t;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  // True for addresses that never hold state: beyond the array, or x0 when hardwired.
  function automatic logic isIgnored(input int addr, input int nregs, input bit hwZero);
    return (addr >= nregs) || (hwZero && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by issue, cleared by writeback (set wins), bulk clear.
// Lookups are combinational; set/clear enables arrive already validated by the caller.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS         = NREGS_DEFAULT,
  parameter int AW            = $clog2(NREGS),
  parameter int NRD           = 2,
  parameter bit HARDWIRE_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clearAll,
  input  logic              setEn,
  input  logic [AW-1:0]     setAddr,
  input  logic              clrEn,
  input  logic [AW-1:0]     clrAddr,
  input  logic [NRD*AW-1:0] lookupAddr,
  output logic [NRD-1:0]    lookupBusy
);

  logic [NREGS-1:0] busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (clearAll) begin
      busy <= '0;
    end else begin
      if (clrEn) busy[clrAddr] <= 1'b0;
      // Applied last so a same-cycle reissue keeps the register busy.
      if (setEn) busy[setAddr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : gLookup
    logic [AW-1:0] addr;
    assign addr          = lookupAddr[i*AW +: AW];
    assign lookupBusy[i] = !isIgnored(32'(addr), NREGS, HARDWIRE_ZERO) && busy[addr];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with post-reset clear engine and busy scoreboard; reads are zero latency.
// Writes and scoreboard sets are dropped while clearing; define REGFILE_BYPASS_EN for write-through forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN          = XLEN_DEFAULT,
  parameter int NREGS         = NREGS_DEFAULT,
  parameter int AW            = $clog2(NREGS),
  parameter int NRD           = 2,
  parameter bit HARDWIRE_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                soft_clear,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_set_addr,
  output logic                init_done
);

  state_t          state;
  logic [AW-1:0]   clrIdx;
  logic [XLEN-1:0] mem [NREGS];
  logic [NRD-1:0]  sbBusy;
  logic            wrOk;
  logic            setOk;

  assign wrOk  = (state == READY) && we && !isIgnored(32'(wr_addr), NREGS, HARDWIRE_ZERO);
  assign setOk = (state == READY) && sb_set && !isIgnored(32'(sb_set_addr), NREGS, HARDWIRE_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clrIdx    <= '0;
      init_done <= 1'b0;
    end else if (soft_clear) begin
      state     <= CLEAR;
      clrIdx    <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clrIdx == AW'(NREGS - 1)) begin
            state     <= READY;
            init_done <= 1'b1;
          end else begin
            clrIdx <= clrIdx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset; the clear engine zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clrIdx] <= '0;
    end else if (wrOk) begin
      mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS        (NREGS),
    .AW           (AW),
    .NRD          (NRD),
    .HARDWIRE_ZERO(HARDWIRE_ZERO)
  ) uScoreboard (
    .clk       (clk),
    .rst       (rst),
    .clearAll  (soft_clear || (state == CLEAR)),
    .setEn     (setOk),
    .setAddr   (sb_set_addr),
    .clrEn     (wrOk),
    .clrAddr   (wr_addr),
    .lookupAddr(rd_addr),
    .lookupBusy(sbBusy)
  );

  for (genvar i = 0; i < NRD; i++) begin : gRead
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busyOut;

    assign addr = rd_addr[i*AW +: AW];

    always_comb begin
      data    = '0;
      busyOut = 1'b0;
      if ((state == READY) && !isIgnored(32'(addr), NREGS, HARDWIRE_ZERO)) begin
        data    = mem[addr];
        busyOut = sbBusy[i];
`ifdef REGFILE_BYPASS_EN
        if (wrOk && (wr_addr == addr)) begin
          data    = wr_data;
          busyOut = setOk && (sb_set_addr == addr);
        end
`endif
      end
    end

    assign rd_data[i*XLEN +: XLEN] = data;
    assign rd_busy[i]              = busyOut;
  end

endmodule
